data_sram_responder: RTL and testbench

Responder end of the CPU core's sram-like data-memory port: accepts load/store requests from the execute stage and returns read data to the memory-access stage, which performs byte/halfword/LWL/LWR extraction on the full returned word. Contains a word-addressed storage array, a fixed-latency response pipeline and an outstanding-request limiter. It backs the data port in simulation and FPGA bring-up, with an injectable address-phase stall for exercising pipeline backpressure.

---
 rtl/data_sram_responder_if.sv | 23 ++
 rtl/data_sram_responder.sv | 106 ++++++++++
 tb/tb_data_sram_responder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_responder_if.sv
// Request/response bundle of the sram-like data port: requester (master) and responder (slave) views.
// Pure wiring; addr_ok/data_ok/rdata return from the responder, all other fields travel towards it.
interface data_sram_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Word-addressed data memory answering sram-like load/store requests in acceptance order.
// Latency: fixed READ_LATENCY cycles from accept to a one-cycle data_ok pulse.
// Backpressure: addr_ok drops at MAX_OUTSTANDING in flight or on accept_stall; responses are never held.
module data_sram_responder #(
    parameter int ADDR_WIDTH      = 14,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    data_sram_responder_if.slave data_sram,
    input  logic                 accept_stall,
    output logic                 protocol_error
);
    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic        vld;
        logic        wr;
        logic [31:0] dat;
    } resp_t;

    logic [31:0]           mem_q [DEPTH];
    resp_t                 resp_q [READ_LATENCY];
    resp_t                 resp_d [READ_LATENCY];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  accept;
    logic                  bad_req;
    logic                  resp_out;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           rd_word;
    logic                  unused_addr_bits;

    // Upper address bits alias onto the array; they take no part in indexing.
    assign word_idx         = data_sram.addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^data_sram.addr[31:ADDR_WIDTH+2];
    assign rd_word          = mem_q[word_idx];

    assign data_sram.addr_ok = reset & ~accept_stall & (cnt_q < CNT_MAX);
    assign accept            = data_sram.req & data_sram.addr_ok;
    assign resp_out          = resp_q[READ_LATENCY-1].vld;

    always_comb begin
        bad_req = 1'b0;
        case (data_sram.size)
            2'd1:    bad_req = data_sram.addr[0];
            2'd2:    bad_req = |data_sram.addr[1:0];
            2'd3:    bad_req = 1'b1;
            default: bad_req = 1'b0;
        endcase
        if (data_sram.wr && (data_sram.wstrb == 4'h0)) begin
            bad_req = 1'b1;
        end
    end

    always_comb begin
        resp_d[0].vld = accept;
        resp_d[0].wr  = data_sram.wr;
        resp_d[0].dat = (accept & ~data_sram.wr) ? rd_word : 32'h0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            resp_d[i] = resp_q[i-1];
        end

        cnt_d = cnt_q;
        case ({accept, resp_out})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        err_d = err_q | (accept & bad_req);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                resp_q[i] <= '0;
            end
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            resp_q <= resp_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Storage survives reset so pre-reset stores stay readable.
    always_ff @(posedge clock) begin
        if (accept && data_sram.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram.wstrb[b]) begin
                    mem_q[word_idx][8*b +: 8] <= data_sram.wdata[8*b +: 8];
                end
            end
        end
    end

    assign data_sram.data_ok = resp_out;
    assign data_sram.rdata   = (resp_out & ~resp_q[READ_LATENCY-1].wr) ? resp_q[READ_LATENCY-1].dat : 32'h0;
    assign protocol_error    = err_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed vector table, queue-based reference model under random traffic,
// and a long-latency instance exercising the outstanding limiter.
module tb_data_sram_responder;
    localparam int AW    = 14;
    localparam int LAT_A = 2;
    localparam int MAX_A = 2;
    localparam int LAT_B = 4;
    localparam int MAX_B = 2;

    typedef struct {
        bit          rst_n;
        bit          req;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        bit          stall;
        bit          e_aok;
        bit          e_dok;
        logic [31:0] e_rd;
        bit          e_err;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] dat;
    } pend_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_a_n, stall_a, err_a;
    logic rst_b_n, stall_b, err_b;
    data_sram_responder_if ifa ();
    data_sram_responder_if ifb ();

    data_sram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT_A), .MAX_OUTSTANDING(MAX_A)) dut_a (
        .clock(clock), .reset(rst_a_n), .data_sram(ifa),
        .accept_stall(stall_a), .protocol_error(err_a)
    );

    data_sram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT_B), .MAX_OUTSTANDING(MAX_B)) dut_b (
        .clock(clock), .reset(rst_b_n), .data_sram(ifb),
        .accept_stall(stall_b), .protocol_error(err_b)
    );

    // Reference model: pending responses with due cycles, word store, sticky error.
    pend_t       mq[$];
    logic [31:0] mmem[int];
    bit          merr;
    int          cyc;
    int          n_chk;
    int          n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit rst_n, input bit req, input bit wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                                input bit stall, input bit aok, input bit dok, input logic [31:0] rd,
                                input bit err);
        vec_t v;
        v.rst_n = rst_n; v.req = req; v.wr = wr; v.size = size; v.addr = addr;
        v.wstrb = wstrb; v.wdata = wdata; v.stall = stall;
        v.e_aok = aok; v.e_dok = dok; v.e_rd = rd; v.e_err = err;
        return v;
    endfunction

    function automatic bit is_bad(input vec_t v);
        return (v.size == 2'd3) || (v.size == 2'd1 && v.addr[0]) ||
               (v.size == 2'd2 && v.addr[1:0] != 2'b00) || (v.wr && v.wstrb == 4'h0);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Applies one cycle of stimulus to dut_a; called just after a falling edge.
    task automatic step_a(input vec_t v, input bit use_tab, output bit acc);
        bit          m_aok, m_dok, e_aok, e_dok, e_err;
        logic [31:0] m_rd, e_rd, old;
        int          key;
        ifa.req = v.req; ifa.wr = v.wr; ifa.size = v.size; ifa.addr = v.addr;
        ifa.wstrb = v.wstrb; ifa.wdata = v.wdata;
        rst_a_n = v.rst_n; stall_a = v.stall;
        #1;
        m_aok = v.rst_n && !v.stall && (mq.size() < MAX_A);
        m_dok = (mq.size() > 0) && (mq[0].due == cyc);
        m_rd  = m_dok ? mq[0].dat : 32'h0;
        e_aok = use_tab ? v.e_aok : m_aok;
        e_dok = use_tab ? v.e_dok : m_dok;
        e_rd  = use_tab ? v.e_rd  : m_rd;
        e_err = use_tab ? v.e_err : merr;
        chk("addr_ok", 32'(ifa.addr_ok), 32'(e_aok));
        if (v.rst_n) begin
            chk("data_ok", 32'(ifa.data_ok), 32'(e_dok));
            chk("rdata", ifa.rdata, e_rd);
        end
        chk("protocol_error", 32'(err_a), 32'(e_err));
        acc = v.req && m_aok;
        @(posedge clock);
        if (!v.rst_n) begin
            mq.delete();
            merr = 1'b0;
        end else begin
            if (mq.size() > 0 && mq[0].due == cyc) void'(mq.pop_front());
            if (acc) begin
                key = int'(v.addr[AW+1:2]);
                old = mmem.exists(key) ? mmem[key] : 32'bx;
                if (v.wr) begin
                    mmem[key] = merge(old, v.wdata, v.wstrb);
                    mq.push_back('{cyc + LAT_A, 32'h0});
                end else begin
                    mq.push_back('{cyc + LAT_A, old});
                end
                if (is_bad(v)) merr = 1'b1;
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    initial begin
        vec_t        tab[$];
        vec_t        cur;
        vec_t        ld;
        vec_t        idle;
        vec_t        rst;
        bit          acc;
        bit          have;
        bit          got;
        int          pool[8];
        int          k;
        logic [31:0] a;
        logic [31:0] bdat[8];
        int          acc_cyc[8];
        int          exp_acc[8];
        bit          aok_hist[40];
        int          nresp, first_dok, last_dok, kb;

        n_chk = 0; n_err = 0; cyc = 0; merr = 1'b0;
        rst_a_n = 1'b0; stall_a = 1'b0; rst_b_n = 1'b0; stall_b = 1'b0;
        ifa.req = 1'b0; ifa.wr = 1'b0; ifa.size = 2'd0; ifa.addr = 32'h0; ifa.wstrb = 4'h0; ifa.wdata = 32'h0;
        ifb.req = 1'b0; ifb.wr = 1'b0; ifb.size = 2'd0; ifb.addr = 32'h0; ifb.wstrb = 4'h0; ifb.wdata = 32'h0;
        repeat (2) @(negedge clock);

        // Directed table for dut_a (latency 2, two outstanding).
        ld   = mk(1, 1, 0, 2'd2, 32'h100, 4'h0, 32'h0, 0, 1, 0, 32'h0, 0);
        idle = mk(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 32'h0, 0);
        rst  = mk(0, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0, 0);
        tab.push_back(rst);
        tab.push_back(idle);
        tab.push_back(mk(1, 1, 1, 2'd2, 32'h100, 4'hF, 32'h1234_5678, 0, 1, 0, 32'h0, 0));
        tab.push_back(ld);
        tab.push_back(mk(1, 1, 1, 2'd0, 32'h103, 4'h8, 32'hAA00_0000, 0, 0, 1, 32'h0, 0));
        tab.push_back(mk(1, 1, 1, 2'd0, 32'h103, 4'h8, 32'hAA00_0000, 0, 1, 1, 32'h1234_5678, 0));
        tab.push_back(ld);
        tab.push_back(mk(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 32'h0, 0));
        tab.push_back(mk(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 1, 1, 32'hAA34_5678, 0));
        tab.push_back(idle);
        tab.push_back(mk(1, 1, 0, 2'd1, 32'h101, 4'h0, 32'h0, 0, 1, 0, 32'h0, 0));
        tab.push_back(mk(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 32'h0, 1));
        tab.push_back(mk(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 1, 1, 32'hAA34_5678, 1));
        tab.push_back(mk(0, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0, 1));
        tab.push_back(idle);
        for (int i = 0; i < 5; i++) tab.push_back(mk(1, 1, 0, 2'd2, 32'h100, 4'h0, 32'h0, 1, 0, 0, 32'h0, 0));
        tab.push_back(ld);
        tab.push_back(ld);
        tab.push_back(rst);
        tab.push_back(idle);
        tab.push_back(idle);
        tab.push_back(ld);
        tab.push_back(idle);
        tab.push_back(mk(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 1, 1, 32'hAA34_5678, 0));
        tab.push_back(mk(1, 1, 1, 2'd2, 32'h200, 4'h0, 32'hDEAD_BEEF, 0, 1, 0, 32'h0, 0));
        tab.push_back(mk(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 32'h0, 1));
        tab.push_back(mk(1, 1, 0, 2'd2, 32'h0001_0100, 4'h0, 32'h0, 0, 1, 1, 32'h0, 1));
        tab.push_back(mk(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 32'h0, 1));
        tab.push_back(mk(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 1, 1, 32'hAA34_5678, 1));
        tab.push_back(mk(0, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0, 1));
        tab.push_back(idle);
        foreach (tab[i]) step_a(tab[i], 1'b1, acc);

        // Random traffic on a pool of words, each written in full first so loads are defined.
        pool = '{0, 1, 2, 3, 64, 100, 5000, 16383};
        for (int p = 0; p < 8; p++) begin
            a = $urandom();
            a[AW+1:2] = 14'(pool[p]);
            a[1:0] = 2'b00;
            cur = mk(1, 1, 1, 2'd2, a, 4'hF, $urandom(), 0, 0, 0, 32'h0, 0);
            acc = 1'b0;
            for (int t = 0; t < 10 && !acc; t++) step_a(cur, 1'b0, acc);
            chk("init_accept", 32'(acc), 32'd1);
        end
        have = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!have && $urandom_range(9) < 7) begin
                k = $urandom_range(7);
                a = $urandom();
                a[AW+1:2] = 14'(pool[k]);
                cur.wr = 1'($urandom_range(1));
                cur.size = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
                if ($urandom_range(9) != 0) begin
                    if (cur.size == 2'd2) a[1:0] = 2'b00;
                    else if (cur.size == 2'd1) a[0] = 1'b0;
                end
                cur.addr = a;
                cur.wstrb = 4'($urandom_range(15));
                cur.wdata = $urandom();
                have = 1'b1;
            end
            cur.req = have;
            cur.stall = ($urandom_range(4) == 0);
            cur.rst_n = ($urandom_range(99) != 0);
            step_a(cur, 1'b0, acc);
            if (acc) have = 1'b0;
        end
        ifa.req = 1'b0;

        // dut_b (latency 4, two outstanding): eight loads with req held high.
        for (int i = 0; i < 8; i++) begin
            bdat[i] = $urandom();
            acc_cyc[i] = -1;
        end
        exp_acc = '{0, 1, 5, 6, 10, 11, 15, 16};
        rst_b_n = 1'b0;
        repeat (2) @(negedge clock);
        rst_b_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifb.req = 1'b1; ifb.wr = 1'b1; ifb.size = 2'd2; ifb.addr = 32'h400 + 32'(i * 4);
            ifb.wstrb = 4'hF; ifb.wdata = bdat[i];
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                #1;
                got = ifb.addr_ok;
                @(negedge clock);
            end
            chk("b_store_accept", 32'(got), 32'd1);
        end
        ifb.req = 1'b0;
        repeat (10) @(negedge clock);
        kb = 0; nresp = 0; first_dok = -1; last_dok = -1;
        for (int t = 0; t < 40; t++) begin
            ifb.req = (kb < 8); ifb.wr = 1'b0; ifb.size = 2'd2; ifb.addr = 32'h400 + 32'(kb * 4);
            ifb.wstrb = 4'h0;
            #1;
            aok_hist[t] = ifb.addr_ok;
            if (ifb.data_ok) begin
                if (first_dok < 0) first_dok = t;
                last_dok = t;
                if (nresp < 8) chk($sformatf("b_rdata%0d", nresp), ifb.rdata, bdat[nresp]);
                nresp++;
            end
            if (ifb.req && ifb.addr_ok) begin
                acc_cyc[kb] = t;
                kb++;
            end
            @(negedge clock);
        end
        for (int i = 0; i < 8; i++) chk($sformatf("b_accept_cycle%0d", i), 32'(acc_cyc[i]), 32'(exp_acc[i]));
        for (int t = 2; t <= 4; t++) chk($sformatf("b_addr_ok_low%0d", t), 32'(aok_hist[t]), 32'd0);
        chk("b_addr_ok_back", 32'(aok_hist[5]), 32'd1);
        chk("b_first_data_ok", 32'(first_dok), 32'd4);
        chk("b_last_data_ok", 32'(last_dok), 32'd20);
        chk("b_resp_count", 32'(nresp), 32'd8);
        chk("b_protocol_error", 32'(err_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
